// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory-port arbiter: store widths, FSM states, grant sides.
// Pure declarations; no latency or backpressure of its own.
package mem_port_arbiter_pkg;

  localparam logic [1:0] WB_BYTE = 2'b01;
  localparam logic [1:0] WB_HEX  = 2'b10;
  localparam logic [1:0] WB_WORD = 2'b11;

  localparam logic [1:0] ARB_IDLE   = 2'd0;
  localparam logic [1:0] ARB_ACCESS = 2'd1;
  localparam logic [1:0] ARB_DONE   = 2'd2;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_LS = 1'b1;

  typedef struct packed {
    logic [3:0]  strb;
    logic [31:0] wdata;
  } lane_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester (IF, LS) and memory-bus signals of the shared port, grouped for one port list.
// slave = arbiter view; master = core plus RAM view.
interface mem_port_arbiter_if;

  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;

  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [1:0]  ls_wb_op;
  logic        ls_ack;
  logic [31:0] ls_rdata;

  logic        bus_en;
  logic [3:0]  bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  logic        busy;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_wb_op, bus_rdata,
    output if_ack, if_rdata, ls_ack, ls_rdata, bus_en, bus_we, bus_addr, bus_wdata, busy
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_wb_op, bus_rdata,
    input  if_ack, if_rdata, ls_ack, ls_rdata, bus_en, bus_we, bus_addr, bus_wdata, busy
  );

endinterface

// File: rtl/mem_port_arbiter_wstrb_gen.sv
// Byte-lane strobes and lane-replicated store data from address low bits and store width.
// Combinational, zero latency; no backpressure.
module mem_port_arbiter_wstrb_gen
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [1:0]  wb_op,
  input  logic [31:0] wdata,
  output lane_t       lane
);

  always_comb begin
    lane.strb  = 4'b1111;
    lane.wdata = wdata;
    case (wb_op)
      WB_BYTE: begin
        lane.strb  = 4'b0001 << addr;
        lane.wdata = {4{wdata[7:0]}};
      end
      WB_HEX: begin
        lane.strb  = addr[1] ? 4'b1100 : 4'b0011;
        lane.wdata = {2{wdata[15:0]}};
      end
      // WB_WORD and the reserved code both write the whole word
      default: begin
        lane.strb  = 4'b1111;
        lane.wdata = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (IF) and load/store (LS); LS priority bounded by STARVE_MAX.
// Latency: RD_LAT+1 (load/fetch) or 2 (store) cycles to ack; requests are held until ack, one access in flight.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 4
) (
  input logic               cpu_clk,
  input logic               cpu_rst_n,
  mem_port_arbiter_if.slave ifc
);

  localparam int                SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]     STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [2:0]        LAT_LOAD   = 3'(RD_LAT);

  logic [1:0]    state;
  logic          grant;
  logic [2:0]    lat_cnt;
  logic [SW-1:0] starve_cnt;
  logic [31:0]   bus_addr_q;
  logic [31:0]   bus_wdata_q;
  logic [3:0]    bus_we_q;
  logic [31:0]   if_rdata_q;
  logic [31:0]   ls_rdata_q;
  lane_t         ls_lane;
  logic          pick_ls;
  logic          unused_bits;

  assign unused_bits = ^ifc.if_addr[1:0];

  mem_port_arbiter_wstrb_gen u_wstrb_gen (
    .addr  (ifc.ls_addr[1:0]),
    .wb_op (ifc.ls_wb_op),
    .wdata (ifc.ls_wdata),
    .lane  (ls_lane)
  );

  // IF wins only when it has waited through STARVE_MAX back-to-back LS grants
  assign pick_ls = ifc.ls_req && !(ifc.if_req && (starve_cnt == STARVE_LIM));

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst_n) begin
      state       <= ARB_IDLE;
      grant       <= GNT_IF;
      lat_cnt     <= '0;
      starve_cnt  <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_we_q    <= '0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (ifc.if_req || ifc.ls_req) begin
            state <= ARB_ACCESS;
            if (pick_ls) begin
              grant      <= GNT_LS;
              bus_addr_q <= {ifc.ls_addr[31:2], 2'b00};
              if (ifc.ls_we) begin
                bus_we_q    <= ls_lane.strb;
                bus_wdata_q <= ls_lane.wdata;
                lat_cnt     <= 3'd1;
              end else begin
                bus_we_q    <= '0;
                bus_wdata_q <= '0;
                lat_cnt     <= LAT_LOAD;
              end
              if (!ifc.if_req)
                starve_cnt <= '0;
              else if (starve_cnt != STARVE_LIM)
                starve_cnt <= starve_cnt + 1'b1;
            end else begin
              grant       <= GNT_IF;
              bus_addr_q  <= {ifc.if_addr[31:2], 2'b00};
              bus_we_q    <= '0;
              bus_wdata_q <= '0;
              lat_cnt     <= LAT_LOAD;
              starve_cnt  <= '0;
            end
          end
        end
        ARB_ACCESS: begin
          lat_cnt <= lat_cnt - 3'd1;
          if (lat_cnt == 3'd1) begin
            state <= ARB_DONE;
            // stores leave the previously captured read data untouched
            if (bus_we_q == 4'b0000) begin
              if (grant == GNT_LS) ls_rdata_q <= ifc.bus_rdata;
              else                 if_rdata_q <= ifc.bus_rdata;
            end
          end
        end
        ARB_DONE: state <= ARB_IDLE;
        default:  state <= ARB_IDLE;
      endcase
    end
  end

  assign ifc.bus_en    = (state == ARB_ACCESS);
  assign ifc.bus_we    = (state == ARB_ACCESS) ? bus_we_q : 4'b0000;
  assign ifc.bus_addr  = bus_addr_q;
  assign ifc.bus_wdata = bus_wdata_q;
  assign ifc.if_ack    = (state == ARB_DONE) && (grant == GNT_IF);
  assign ifc.ls_ack    = (state == ARB_DONE) && (grant == GNT_LS);
  assign ifc.if_rdata  = if_rdata_q;
  assign ifc.ls_rdata  = ls_rdata_q;
  assign ifc.busy      = (state != ARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter (RD_LAT=2, STARVE_MAX=4).
// Stimulus pushes expected accesses; a negedge monitor pops and compares on each ack.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int RD_LAT     = 2;
  localparam int STARVE_MAX = 4;

  logic cpu_clk   = 1'b0;
  logic cpu_rst_n = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  mem_port_arbiter_if ifc();

  mem_port_arbiter #(.RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .cpu_clk   (cpu_clk),
    .cpu_rst_n (cpu_rst_n),
    .ifc       (ifc)
  );

  typedef struct {
    logic        side;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          len;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always @(posedge cpu_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // RAM model: read data only becomes valid after RD_LAT enabled cycles
  int en_cnt = 0;
  always @(posedge cpu_clk) en_cnt <= (ifc.bus_en === 1'b1) ? en_cnt + 1 : 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0000_1004) ? 32'h0280_0413 : {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  assign ifc.bus_rdata = ((ifc.bus_en === 1'b1) && (en_cnt >= RD_LAT - 1)) ?
                         mem_word(ifc.bus_addr) : 32'hDEAD_DEAD;

  // Monitor
  logic        in_acc = 1'b0;
  logic [31:0] a_addr = '0;
  logic [31:0] a_wdata = '0;
  logic [3:0]  a_we = '0;
  int          a_len = 0;
  exp_t        mon_e;

  always @(negedge cpu_clk) begin
    if (ifc.bus_en === 1'b1) begin
      if (!in_acc) begin
        in_acc  = 1'b1;
        a_addr  = ifc.bus_addr;
        a_we    = ifc.bus_we;
        a_wdata = ifc.bus_wdata;
        a_len   = 1;
      end else begin
        a_len++;
        chk("bus_addr_stable", ifc.bus_addr, a_addr);
        chk("bus_we_stable", 32'(ifc.bus_we), 32'(a_we));
        chk("bus_wdata_stable", ifc.bus_wdata, a_wdata);
      end
    end else begin
      in_acc = 1'b0;
    end

    if (ifc.if_ack === 1'b1 || ifc.ls_ack === 1'b1) begin
      chk("ack_exclusive", 32'(ifc.if_ack & ifc.ls_ack), 32'd0);
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ack: got if_ack=%b ls_ack=%b want none (cycle %0d)",
                 ifc.if_ack, ifc.ls_ack, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("grant_side", 32'(ifc.ls_ack), 32'(mon_e.side));
        chk("bus_addr", a_addr, mon_e.addr);
        chk("bus_we", 32'(a_we), 32'(mon_e.we));
        if (mon_e.we != 4'b0000)
          chk("bus_wdata", a_wdata, mon_e.wdata);
        else if (mon_e.side == GNT_LS)
          chk("ls_rdata", ifc.ls_rdata, mon_e.rdata);
        else
          chk("if_rdata", ifc.if_rdata, mon_e.rdata);
        chk("bus_en_cycles", 32'(a_len), 32'(mon_e.len));
        chk("ack_cycle", 32'(cyc), 32'(mon_e.cyc));
        chk("done_bus_idle", {27'd0, ifc.bus_en, ifc.bus_we}, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic push(input logic side, input logic [31:0] addr, input logic [3:0] we,
                      input logic [31:0] wdata, input logic [31:0] rdata,
                      input int len, input int c);
    exp_t e;
    e.side = side; e.addr = addr; e.we = we; e.wdata = wdata;
    e.rdata = rdata; e.len = len; e.cyc = c;
    sb.push_back(e);
  endtask

  // Returns #1 after the edge that ends the n-th ack cycle (DUT back in IDLE)
  task automatic wait_acks(input int n, input int budget);
    int got = 0;
    for (int i = 0; i < budget && got < n; i++) begin
      @(negedge cpu_clk);
      if (ifc.if_ack === 1'b1 || ifc.ls_ack === 1'b1) got++;
    end
    if (got < n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ack_timeout: got %0d acks want %0d", got, n);
    end
    tick();
  endtask

  task automatic ls_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] op, input logic [31:0] exp_addr,
                       input logic [3:0] exp_we, input logic [31:0] exp_wdata,
                       input logic [31:0] exp_rdata);
    ifc.ls_req   = 1'b1;
    ifc.ls_we    = we;
    ifc.ls_addr  = addr;
    ifc.ls_wdata = wdata;
    ifc.ls_wb_op = op;
    push(GNT_LS, exp_addr, exp_we, exp_wdata, exp_rdata,
         we ? 1 : RD_LAT, we ? cyc + 2 : cyc + RD_LAT + 1);
    wait_acks(1, 20);
    ifc.ls_req = 1'b0;
  endtask

  logic [9:0] gseq;
  int         c0;

  initial begin
    ifc.if_req = 1'b0; ifc.if_addr = '0;
    ifc.ls_req = 1'b0; ifc.ls_we = 1'b0; ifc.ls_addr = '0;
    ifc.ls_wdata = '0; ifc.ls_wb_op = WB_WORD;

    repeat (2) @(posedge cpu_clk);
    #1;
    chk("rst_bus_en", 32'(ifc.bus_en), 32'd0);
    chk("rst_bus_we", 32'(ifc.bus_we), 32'd0);
    chk("rst_bus_addr", ifc.bus_addr, 32'd0);
    chk("rst_bus_wdata", ifc.bus_wdata, 32'd0);
    chk("rst_acks", 32'({ifc.if_ack, ifc.ls_ack}), 32'd0);
    chk("rst_if_rdata", ifc.if_rdata, 32'd0);
    chk("rst_ls_rdata", ifc.ls_rdata, 32'd0);
    chk("rst_busy", 32'(ifc.busy), 32'd0);
    cpu_rst_n = 1'b1;
    tick();

    // Fetch only
    ifc.if_req  = 1'b1;
    ifc.if_addr = 32'h0000_1004;
    push(GNT_IF, 32'h0000_1004, 4'b0000, 32'h0, 32'h0280_0413, 2, cyc + 3);
    wait_acks(1, 20);
    ifc.if_req = 1'b0;

    // Stores across widths and lanes, then a load
    ls_op(1'b1, 32'h0000_2003, 32'h0000_00A5, WB_BYTE, 32'h0000_2000, 4'b1000, 32'hA5A5_A5A5, 32'h0);
    ls_op(1'b1, 32'h0000_2002, 32'h0000_1234, WB_HEX,  32'h0000_2000, 4'b1100, 32'h1234_1234, 32'h0);
    ls_op(1'b1, 32'h0000_2000, 32'h0000_FF5A, WB_BYTE, 32'h0000_2000, 4'b0001, 32'h5A5A_5A5A, 32'h0);
    ls_op(1'b1, 32'h0000_2001, 32'h0000_003C, WB_BYTE, 32'h0000_2000, 4'b0010, 32'h3C3C_3C3C, 32'h0);
    ls_op(1'b1, 32'h0000_2001, 32'hFFFF_BEEF, WB_HEX,  32'h0000_2000, 4'b0011, 32'hBEEF_BEEF, 32'h0);
    ls_op(1'b1, 32'h0000_2004, 32'hCAFE_F00D, WB_WORD, 32'h0000_2004, 4'b1111, 32'hCAFE_F00D, 32'h0);
    ls_op(1'b1, 32'h0000_2007, 32'h0123_4567, 2'b00,   32'h0000_2004, 4'b1111, 32'h0123_4567, 32'h0);
    ls_op(1'b0, 32'h0000_3009, 32'h0,         WB_WORD, 32'h0000_3008, 4'b0000, 32'h0,         32'h8EE7_3008);

    // Contention: both held high; bit k = 1 means LS wins grant k
    gseq = 10'b0111101111;
    c0 = cyc;
    ifc.if_req  = 1'b1; ifc.if_addr = 32'h0000_0103;
    ifc.ls_req  = 1'b1; ifc.ls_we = 1'b0; ifc.ls_addr = 32'h0000_3008;
    for (int k = 0; k < 10; k++) begin
      if (gseq[k])
        push(GNT_LS, 32'h0000_3008, 4'b0000, 32'h0, 32'h8EE7_3008, 2, c0 + 3 + 4 * k);
      else
        push(GNT_IF, 32'h0000_0100, 4'b0000, 32'h0, 32'hBFEF_0100, 2, c0 + 3 + 4 * k);
    end
    wait_acks(10, 80);
    ifc.if_req = 1'b0;
    ifc.ls_req = 1'b0;
    tick();

    // Reset during the ACCESS cycle of a store
    ifc.ls_req = 1'b1; ifc.ls_we = 1'b1; ifc.ls_addr = 32'h0000_2004;
    ifc.ls_wdata = 32'h1111_2222; ifc.ls_wb_op = WB_WORD;
    tick();
    chk("pre_rst_bus_en", 32'(ifc.bus_en), 32'd1);
    cpu_rst_n = 1'b0;
    tick();
    chk("post_rst_bus_en", 32'(ifc.bus_en), 32'd0);
    chk("post_rst_bus_we", 32'(ifc.bus_we), 32'd0);
    chk("post_rst_ls_ack", 32'(ifc.ls_ack), 32'd0);
    chk("post_rst_busy", 32'(ifc.busy), 32'd0);
    push(GNT_LS, 32'h0000_2004, 4'b1111, 32'h1111_2222, 32'h0, 1, cyc + 2);
    cpu_rst_n = 1'b1;
    wait_acks(1, 20);
    ifc.ls_req = 1'b0;
    tick();

    // Simultaneous first requests: LS first, IF acked RD_LAT+2 cycles later
    c0 = cyc;
    ifc.if_req = 1'b1; ifc.if_addr = 32'h0000_1004;
    ifc.ls_req = 1'b1; ifc.ls_we = 1'b0; ifc.ls_addr = 32'h0000_3008;
    push(GNT_LS, 32'h0000_3008, 4'b0000, 32'h0, 32'h8EE7_3008, 2, c0 + 3);
    push(GNT_IF, 32'h0000_1004, 4'b0000, 32'h0, 32'h0280_0413, 2, c0 + 3 + RD_LAT + 2);
    wait_acks(1, 20);
    ifc.ls_req = 1'b0;
    wait_acks(1, 20);
    ifc.if_req = 1'b0;

    repeat (4) tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
